// File: rtl/vga_text_timing.sv
// vga_text_timing: pixel/line timing, character-cell addressing and sync generation for a text-mode VGA display.
// Optional blinking cursor overlay is compiled in when VGA_TEXT_TIMING_CURSOR_EN is defined.
module vga_text_timing #(
  parameter int CLK_FACTOR   = 4,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit HS_POL       = 1'b0,
  parameter bit VS_POL       = 1'b0,
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int SYNC_DELAY   = 2,
  parameter int BLINK_FRAMES = 30,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int COLS    = H_ACTIVE / GLYPH_W,
  localparam int ROWS    = V_ACTIVE / GLYPH_H,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL),
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int GX_W    = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1,
  localparam int GY_W    = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1,
  localparam int ADDR_W  = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cursor_en_i,
  input  logic [COL_W-1:0]  cursor_col_i,
  input  logic [ROW_W-1:0]  cursor_row_i,
  output logic              pixel_tick_o,
  output logic [HW-1:0]     hcount_o,
  output logic [VW-1:0]     vcount_o,
  output logic              pixel_enable_o,
  output logic [COL_W-1:0]  col_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [GX_W-1:0]   glyph_x_o,
  output logic [GY_W-1:0]   glyph_y_o,
  output logic [ADDR_W-1:0] ch_addr_o,
  output logic              frame_start_o,
  output logic              vga_hs_o,
  output logic              vga_vs_o,
  output logic              cursor_o
);

  localparam int DIV_W = (CLK_FACTOR > 1) ? $clog2(CLK_FACTOR) : 1;
  localparam int GX_SH = $clog2(GLYPH_W);
  localparam int GY_SH = $clog2(GLYPH_H);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_FACTOR - 1);
  localparam logic [HW-1:0]    H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]    V_LAST   = VW'(V_TOTAL - 1);

  logic [DIV_W-1:0] div_q;
  logic [HW-1:0]    h_q;
  logic [VW-1:0]    v_q;
  logic             tick;
  logic             hs_raw;
  logic             vs_raw;

  // With CLK_FACTOR=1 the divider is pinned at 0, so the tick is permanently high.
  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else if (tick) begin
      if (h_q == H_LAST) begin
        h_q <= '0;
        v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_q <= h_q + 1'b1;
      end
    end
  end

  assign pixel_tick_o   = tick;
  assign hcount_o       = h_q;
  assign vcount_o       = v_q;
  assign pixel_enable_o = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
  assign frame_start_o  = tick && (h_q == '0) && (v_q == '0);

  // Cell coordinates are forced to zero in blanking so the character fetch stays at a harmless address.
  always_comb begin
    col_o     = '0;
    row_o     = '0;
    glyph_x_o = '0;
    glyph_y_o = '0;
    ch_addr_o = '0;
    if (pixel_enable_o) begin
      col_o     = COL_W'(h_q >> GX_SH);
      row_o     = ROW_W'(v_q >> GY_SH);
      glyph_x_o = GX_W'(h_q & HW'(GLYPH_W - 1));
      glyph_y_o = GY_W'(v_q & VW'(GLYPH_H - 1));
      ch_addr_o = ADDR_W'(row_o) * ADDR_W'(COLS) + ADDR_W'(col_o);
    end
  end

  assign hs_raw = ((int'(h_q) >= H_ACTIVE + H_FP) && (int'(h_q) < H_ACTIVE + H_FP + H_SYNC))
                  ? HS_POL : ~HS_POL;
  assign vs_raw = ((int'(v_q) >= V_ACTIVE + V_FP) && (int'(v_q) < V_ACTIVE + V_FP + V_SYNC))
                  ? VS_POL : ~VS_POL;

  // Syncs lag the counters so they line up with pixel data coming back from the glyph BRAM.
  generate
    if (SYNC_DELAY == 0) begin : g_sync_direct
      assign vga_hs_o = hs_raw;
      assign vga_vs_o = vs_raw;
    end else begin : g_sync_pipe
      logic [SYNC_DELAY-1:0] hs_sr;
      logic [SYNC_DELAY-1:0] vs_sr;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          hs_sr <= {SYNC_DELAY{~HS_POL}};
          vs_sr <= {SYNC_DELAY{~VS_POL}};
        end else begin
          hs_sr <= (hs_sr << 1) | SYNC_DELAY'(hs_raw);
          vs_sr <= (vs_sr << 1) | SYNC_DELAY'(vs_raw);
        end
      end
      assign vga_hs_o = hs_sr[SYNC_DELAY-1];
      assign vga_vs_o = vs_sr[SYNC_DELAY-1];
    end
  endgenerate

`ifdef VGA_TEXT_TIMING_CURSOR_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;
  logic          frame_end;
  logic          cursor_raw;

  // Counted on the last tick of a frame, so the phase flips exactly as the next frame_start_o begins.
  assign frame_end = tick && (h_q == H_LAST) && (v_q == V_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (frame_end) begin
      if (int'(blink_cnt_q) == BLINK_FRAMES - 1) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  // Underline cursor: bottom two glyph lines of the selected cell.
  assign cursor_raw = cursor_en_i && blink_phase_q && pixel_enable_o &&
                      (col_o == cursor_col_i) && (row_o == cursor_row_i) &&
                      (int'(glyph_y_o) >= GLYPH_H - 2);

  generate
    if (SYNC_DELAY == 0) begin : g_cur_direct
      assign cursor_o = cursor_raw;
    end else begin : g_cur_pipe
      logic [SYNC_DELAY-1:0] cur_sr;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cur_sr <= '0;
        end else begin
          cur_sr <= (cur_sr << 1) | SYNC_DELAY'(cursor_raw);
        end
      end
      assign cursor_o = cur_sr[SYNC_DELAY-1];
    end
  endgenerate
`else
  wire unused_cursor = &{1'b0, cursor_en_i, cursor_col_i, cursor_row_i, BLINK_FRAMES != 0};
  assign cursor_o = 1'b0;
`endif

endmodule

// File: tb/tb_vga_text_timing.sv
// Bench for vga_text_timing: a default-geometry instance (CLK_FACTOR=1) checked against a coordinate table,
// and a small-geometry instance (CLK_FACTOR=4) checked cycle by cycle, including blink and mid-frame reset.
module tb_vga_text_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   n_checks = 0;
  int   n_errors = 0;

  // Instance A: default 640x480 geometry, one clock per pixel
  logic        a_tick, a_pe, a_fs, a_hs, a_vs, a_cur;
  logic [9:0]  a_hc, a_vc;
  logic [6:0]  a_col;
  logic [4:0]  a_row;
  logic [2:0]  a_gx;
  logic [3:0]  a_gy;
  logic [11:0] a_addr;

  vga_text_timing #(.CLK_FACTOR(1)) u_a (
    .clk_i(clk), .rst_i(rst_a), .cursor_en_i(1'b0), .cursor_col_i(7'd0), .cursor_row_i(5'd0),
    .pixel_tick_o(a_tick), .hcount_o(a_hc), .vcount_o(a_vc), .pixel_enable_o(a_pe),
    .col_o(a_col), .row_o(a_row), .glyph_x_o(a_gx), .glyph_y_o(a_gy), .ch_addr_o(a_addr),
    .frame_start_o(a_fs), .vga_hs_o(a_hs), .vga_vs_o(a_vs), .cursor_o(a_cur)
  );

  // Instance B: 24x12 total, 16x8 active, 4x4 glyphs, 4 clocks per pixel, blink every 2 frames
  logic       b_tick, b_pe, b_fs, b_hs, b_vs, b_cur;
  logic [4:0] b_hc;
  logic [3:0] b_vc;
  logic [1:0] b_col;
  logic [0:0] b_row;
  logic [1:0] b_gx;
  logic [1:0] b_gy;
  logic [2:0] b_addr;

  vga_text_timing #(
    .CLK_FACTOR(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1), .GLYPH_W(4), .GLYPH_H(4),
    .SYNC_DELAY(2), .BLINK_FRAMES(2)
  ) u_b (
    .clk_i(clk), .rst_i(rst_b), .cursor_en_i(1'b1), .cursor_col_i(2'd1), .cursor_row_i(1'b1),
    .pixel_tick_o(b_tick), .hcount_o(b_hc), .vcount_o(b_vc), .pixel_enable_o(b_pe),
    .col_o(b_col), .row_o(b_row), .glyph_x_o(b_gx), .glyph_y_o(b_gy), .ch_addr_o(b_addr),
    .frame_start_o(b_fs), .vga_hs_o(b_hs), .vga_vs_o(b_vs), .cursor_o(b_cur)
  );

  typedef struct {
    int pos;
    int hc, vc, pe, fs, col, row, gx, gy, addr;
  } vec_t;

  vec_t       tbl[8];
  logic [1:0] exp_a_q[$];
  logic [2:0] exp_q[$];
  logic [1:0] ea;
  logic [2:0] eb;
  int         ti, h, v, dv, p, f, cur;

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  initial begin
    // pos = cycles after reset release; fields: hc vc pe fs col row gx gy addr
    tbl[0] = '{0,     0,   0,  1, 1, 0,  0, 0, 0,  0};
    tbl[1] = '{12007, 7,   15, 1, 0, 0,  0, 7, 15, 0};
    tbl[2] = '{12808, 8,   16, 1, 0, 1,  1, 0, 0,  81};
    tbl[3] = '{16100, 100, 20, 1, 0, 12, 1, 4, 4,  92};
    tbl[4] = '{27839, 639, 34, 1, 0, 79, 2, 7, 2,  239};
    tbl[5] = '{27999, 799, 34, 0, 0, 0,  0, 0, 0,  0};
    tbl[6] = '{28017, 17,  35, 1, 0, 2,  2, 1, 3,  162};
    tbl[7] = '{28640, 640, 35, 0, 0, 0,  0, 0, 0,  0};

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);

    check("a_rst_hc", a_hc, 0);
    check("a_rst_vc", a_vc, 0);
    check("a_rst_pe", a_pe, 1);
    check("a_rst_sync", {a_hs, a_vs}, 3);
    check("a_rst_cur", a_cur, 0);

    rst_a = 1'b0;
    exp_a_q.push_back(2'b11);
    exp_a_q.push_back(2'b11);
    ti = 0;
    for (int pos = 0; pos <= 28640; pos++) begin
      h = pos % 800;
      v = pos / 800;
      exp_a_q.push_back({!(h >= 656 && h < 752), !(v >= 490 && v < 492)});
      ea = exp_a_q.pop_front();
      check("a_sync", {a_hs, a_vs}, ea);
      check("a_tick", a_tick, 1);
      if (ti < 8 && tbl[ti].pos == pos) begin
        check("a_tbl_hc", a_hc, tbl[ti].hc);
        check("a_tbl_vc", a_vc, tbl[ti].vc);
        check("a_tbl_pe", a_pe, tbl[ti].pe);
        check("a_tbl_fs", a_fs, tbl[ti].fs);
        check("a_tbl_col", a_col, tbl[ti].col);
        check("a_tbl_row", a_row, tbl[ti].row);
        check("a_tbl_gx", a_gx, tbl[ti].gx);
        check("a_tbl_gy", a_gy, tbl[ti].gy);
        check("a_tbl_addr", a_addr, tbl[ti].addr);
        ti++;
      end
      @(negedge clk);
    end
    check("a_tbl_count", ti, 8);

    // Instance B has been held in reset throughout
    check("b_rst_hc", b_hc, 0);
    check("b_rst_vc", b_vc, 0);
    check("b_rst_pe", b_pe, 1);
    check("b_rst_tick", b_tick, 0);
    check("b_rst_sync", {b_hs, b_vs}, 3);
    check("b_rst_cur", b_cur, 0);

    rst_b = 1'b0;
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b110);
    // Six frames of 1152 cycles, then on to pixel (12,9) inside vsync of frame 6
    for (int c = 0; c < 6912 + (9 * 24 + 12) * 4 + 1; c++) begin
      dv = c % 4;
      p  = c / 4;
      h  = p % 24;
      v  = (p / 24) % 12;
      f  = p / 288;
`ifdef VGA_TEXT_TIMING_CURSOR_EN
      cur = (((f / 2) % 2) == 1 && h < 16 && v < 8 && h / 4 == 1 && v / 4 == 1 && v % 4 >= 2) ? 1 : 0;
`else
      cur = 0;
`endif
      check("b_hc", b_hc, h);
      check("b_vc", b_vc, v);
      check("b_tick", b_tick, (dv == 3) ? 1 : 0);
      check("b_fs", b_fs, (dv == 3 && h == 0 && v == 0) ? 1 : 0);
      check("b_pe", b_pe, (h < 16 && v < 8) ? 1 : 0);
      if (h < 16 && v < 8) begin
        check("b_addr", b_addr, (v / 4) * 4 + h / 4);
        check("b_gxy", {b_gx, b_gy}, (h % 4) * 4 + (v % 4));
      end else begin
        check("b_addr_blank", {b_col, b_row, b_gx, b_gy, b_addr}, 0);
      end
      exp_q.push_back({!(h >= 18 && h < 21), !(v >= 9 && v < 11), cur[0]});
      eb = exp_q.pop_front();
      check("b_sync_cur", {b_hs, b_vs, b_cur}, eb);
      @(negedge clk);
    end

    // Mid-frame reset while vsync is active
    check("b_pre_rst_vs", b_vs, 0);
    check("b_pre_rst_hc", b_hc, 12);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    check("b_post_rst_hc", b_hc, 0);
    check("b_post_rst_vc", b_vc, 0);
    check("b_post_rst_sync", {b_hs, b_vs}, 3);
    check("b_post_rst_cur", b_cur, 0);
    check("b_post_rst_pe", b_pe, 1);
    check("b_post_rst_tick", b_tick, 0);
    check("b_post_rst_fs", b_fs, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("b_post_rst_fs_seq", b_fs, (k == 3) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
